// File: rtl/clock_pkg.sv
// clock_pkg: mode encodings, field limits and widths shared by the time-of-day clock
package clock_pkg;
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;
  localparam int SEC_N  = 60;
  localparam int MIN_N  = 60;
  localparam int HOUR_N = 24;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled mod-N counter with synchronous clear and gated carry
module mod_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         c
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [W-1:0] r_q;
  // count 0..N-1 while enabled; clear wins over enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (en) r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
  end
  assign q = r_q;
  assign c = en & (r_q == LAST);
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: 24-hour clock sequencing a prescaler/sec/min/hour counter chain with set mode
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [1:0]        mode,
  output logic              sec_tick,
  output logic              day_c
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic [PW-1:0] w_pre;
  logic          w_pre_c, w_sec_c, w_min_c, w_hour_c;
  logic          w_run, w_leave, w_inc, w_min_en, w_hour_en;
  // mode register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_mode <= MODE_RUN;
    else r_mode <= w_mode_nxt;
  end
  // mode sequencing RUN -> SET_H -> SET_M -> RUN; stray encodings recover to RUN
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_RUN:   w_mode_nxt = mode_btn ? MODE_SET_H : MODE_RUN;
      MODE_SET_H: w_mode_nxt = mode_btn ? MODE_SET_M : MODE_SET_H;
      MODE_SET_M: w_mode_nxt = mode_btn ? MODE_RUN : MODE_SET_M;
      default:    w_mode_nxt = MODE_RUN;
    endcase
  end
  assign w_run     = (r_mode == MODE_RUN);
  assign w_leave   = (r_mode == MODE_SET_M) & mode_btn;
  assign w_inc     = inc_btn & ~mode_btn;
  assign w_min_en  = w_run ? w_sec_c : (r_mode == MODE_SET_M) & w_inc;
  assign w_hour_en = w_run ? w_min_c : (r_mode == MODE_SET_H) & w_inc;
  mod_counter #(.N(TICK_DIV), .W(PW)) u_pre (
    .clk(clk), .rstn(rstn), .en(w_run), .clr(w_leave), .q(w_pre), .c(w_pre_c)
  );
  mod_counter #(.N(SEC_N), .W(SEC_W)) u_sec (
    .clk(clk), .rstn(rstn), .en(w_pre_c), .clr(w_leave), .q(sec), .c(w_sec_c)
  );
  mod_counter #(.N(MIN_N), .W(MIN_W)) u_min (
    .clk(clk), .rstn(rstn), .en(w_min_en), .clr(1'b0), .q(min), .c(w_min_c)
  );
  mod_counter #(.N(HOUR_N), .W(HOUR_W)) u_hour (
    .clk(clk), .rstn(rstn), .en(w_hour_en), .clr(1'b0), .q(hour), .c(w_hour_c)
  );
  assign mode     = r_mode;
  assign sec_tick = w_run & (w_pre == PRE_LAST);
  assign day_c    = w_run & w_hour_c;
endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-of-day controller that sequences a chain of mod-N counters (prescaler, seconds, minutes, hours) into a 24-hour digital clock, with a button-driven set mode. It sits between the debounced front-panel buttons and the display driver. It owns all counter enables and clears, so no counter in the chain free-runs on its own.

## Interface

- `TICK_DIV`, default 100: clk cycles per second. Legal range is ≥2. Benches use 4.
- `clk` input, 1 bit: system clock, rising-edge.
- `rstn` input, 1 bit: asynchronous active-low reset.
- `mode_btn` input, 1 bit: single-cycle synchronous pulse that advances the mode.
- `inc_btn` input, 1 bit: single-cycle synchronous pulse that increments the selected field.
- `sec` output, 6 bits: seconds, 0..59.
- `min` output, 6 bits: minutes, 0..59.
- `hour` output, 5 bits: hours, 0..23.
- `mode` output, 2 bits: current state. 0=RUN, 1=SET_H, 2=SET_M.
- `sec_tick` output, 1 bit: high for the one cycle in which seconds advance.
- `day_c` output, 1 bit: high for the one cycle in which 23:59:59 rolls to 00:00:00.

## Operation

- States and transitions:
  - RUN goes to SET_H on `mode_btn`.
  - SET_H goes to SET_M on `mode_btn`.
  - SET_M goes to RUN on `mode_btn`.
  - No other transitions exist. Encoding 3 is unreachable; if ever reached, the next edge goes to RUN.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - When the prescaler carries, `sec` increments mod 60.
  - When `sec` carries, `min` increments mod 60.
  - When `min` carries, `hour` increments mod 24.
  - `inc_btn` is ignored.
- SET_H: the prescaler and `sec` are held. `inc_btn` sets `hour` ← (`hour`+1) mod 24, with no carry to other fields.
- SET_M: the prescaler and `sec` are held. `inc_btn` sets `min` ← (`min`+1) mod 60, with no carry into `hour`.
- Leaving SET_M for RUN synchronously clears the prescaler and `sec` to 0 on the same edge as the state change. Time restarts at hh:mm:00.
- Simultaneous `mode_btn` and `inc_btn`: `mode_btn` wins and that `inc_btn` is dropped.
- Carries are gated by enable. A counter sitting at N-1 while disabled never produces a carry.

## Timing

- Reset (`rstn`=0, asynchronous): prescaler=0, `sec`=0, `min`=0, `hour`=0, `mode`=RUN, `sec_tick`=0, `day_c`=0.
- Reset mid-operation from any state forces all of the above immediately. Counting resumes on the first edge after `rstn` deasserts.
- `sec`, `min`, `hour` and `mode` are registered.
- `sec_tick` is combinational: (`mode`==RUN) & (prescaler==TICK_DIV-1). The field update happens on the edge that ends that cycle.
- `day_c` is combinational: `sec_tick` & `sec`==59 & `min`==59 & `hour`==23.
- Seconds period in RUN is exactly TICK_DIV cycles. The first increment after reset comes TICK_DIV edges after `rstn` release.
- A button takes effect on the edge at which it is sampled high. Its result is visible the following cycle.
- `sec_tick` and `day_c` are never asserted outside RUN.

## Structure

- Package `clock_pkg` holds:
  - mode encodings `MODE_RUN`, `MODE_SET_H`, `MODE_SET_M`;
  - limits `SEC_N`=60, `MIN_N`=60, `HOUR_N`=24;
  - field widths 6/6/5.
- Sub-module `mod_counter #(N, W)`:
  - ports `clk`, `rstn`, `en`, `clr`, `q[W-1:0]`, `c`;
  - `clr` is synchronous and has priority over `en`;
  - `c` = `en` & (`q`==N-1).
- `clock_ctrl` instantiates four `mod_counter`s: prescaler, sec, min, hour.
- The FSM and the enable/clear muxing live in `clock_ctrl`.

## Test plan

All scenarios use TICK_DIV=4.

- **Basic count:** release reset, run 4·60 cycles → `min`=1, `sec`=0, `hour`=0. Exactly 60 `sec_tick` pulses are seen, each one cycle wide, spaced 4 cycles apart.
- **Set hour:** `mode_btn`, then 25 `inc_btn` pulses → `mode`=1, `hour`=1 (wrapped past 23). `sec` and the prescaler are frozen throughout.
- **Set minute and resume:**
  - From SET_H, `mode_btn` then 61 `inc_btn` → `min`=1, `hour` unchanged.
  - `mode_btn` → `mode`=0 and `sec`=0.
  - First `sec_tick` arrives exactly 4 cycles later.
- **Day rollover:** set 23:59, return to RUN, run 60·4 cycles → 00:00:00. `day_c` is high for exactly one cycle, coincident with the final `sec_tick`.
- **Button collision:** `mode_btn` and `inc_btn` in the same cycle while in SET_H → `mode`=2 and `hour` unchanged.
- **Async reset:** at 12:34:56 in SET_M, pulse `rstn` low between clock edges → all outputs are 0 and `mode`=RUN before the next edge. Normal counting resumes after release.
